// File: rtl/pwm_multi_channel_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg: shared types and defaults for the multi-channel PWM generator.
//   pwm_state_e           : controller state (IDLE/RUN, plus UP/DOWN when
//                           PWM_CENTER_ALIGNED_EN is defined)
//   PWM_DEFAULT_WIDTH     : default counter/period/duty width
//   PWM_DEFAULT_CHANNELS  : default number of PWM outputs
// Optional feature macro: PWM_CENTER_ALIGNED_EN
// ---------------------------------------------------------------------------
package pwm_pkg;
    localparam int PWM_DEFAULT_WIDTH    = 16;
    localparam int PWM_DEFAULT_CHANNELS = 4;

`ifdef PWM_CENTER_ALIGNED_EN
    // RUN is the edge-aligned count; UP/DOWN are the two halves of a
    // center-aligned period.
    typedef enum logic [1:0] {IDLE, RUN, UP, DOWN} pwm_state_e;
`else
    typedef enum logic {IDLE, RUN} pwm_state_e;
`endif
endpackage

// File: rtl/pwm_multi_channel_if.sv
// ---------------------------------------------------------------------------
// pwm_multi_channel_if: control/status bundle of the PWM generator.
//   enable         : run the counter when high
//   period         : counter terminal value P
//   duty           : packed per-channel compare values, channel i at [i*WIDTH +: WIDTH]
//   load           : sample period/duty into the pending shadow registers
//   center         : center-aligned mode select (PWM_CENTER_ALIGNED_EN only)
//   update_pending : pending values captured, not yet applied
//   period_start   : one-cycle pulse on the first output cycle of a period
//   pwm_out        : PWM outputs
// modport master drives the controls, modport slave is the PWM block.
// Optional feature macro: PWM_CENTER_ALIGNED_EN
// ---------------------------------------------------------------------------
interface pwm_multi_channel_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
);
    logic                      enable;
    logic [WIDTH-1:0]          period;
    logic [CHANNELS*WIDTH-1:0] duty;
    logic                      load;
`ifdef PWM_CENTER_ALIGNED_EN
    logic                      center;
`endif
    logic                      update_pending;
    logic                      period_start;
    logic [CHANNELS-1:0]       pwm_out;

`ifdef PWM_CENTER_ALIGNED_EN
    modport master (output enable, period, duty, load, center,
                    input  update_pending, period_start, pwm_out);
    modport slave  (input  enable, period, duty, load, center,
                    output update_pending, period_start, pwm_out);
`else
    modport master (output enable, period, duty, load,
                    input  update_pending, period_start, pwm_out);
    modport slave  (input  enable, period, duty, load,
                    output update_pending, period_start, pwm_out);
`endif
endinterface

// File: rtl/pwm_compare_channel.sv
// ---------------------------------------------------------------------------
// pwm_compare_channel: one PWM output lane.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_run      : counter is running this cycle (output forced low otherwise)
//   i_apply    : load i_duty into the active duty register at this edge
//   i_cnt      : shared period counter
//   i_duty     : duty value to apply
//   o_pwm      : registered output, high while cnt < active duty
// ---------------------------------------------------------------------------
module pwm_compare_channel #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_run,
    input  logic             i_apply,
    input  logic [WIDTH-1:0] i_cnt,
    input  logic [WIDTH-1:0] i_duty,
    output logic             o_pwm
);
    logic [WIDTH-1:0] r_duty;
    logic             r_pwm;
    logic             w_hit;

    assign w_hit = (i_cnt < r_duty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty <= '0;
            r_pwm  <= 1'b0;
        end else begin
            if (i_apply) r_duty <= i_duty;
            r_pwm <= i_run & w_hit;
        end
    end

    assign o_pwm = r_pwm;
endmodule

// File: rtl/pwm_multi_channel.sv
// ---------------------------------------------------------------------------
// pwm_multi_channel: shared period counter driving CHANNELS duty comparators,
// with double-buffered period/duty updates applied at period boundaries.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pwm_multi_channel_if.slave (controls in, status/outputs out)
// Optional feature macro: PWM_CENTER_ALIGNED_EN (center-aligned up/down count)
// ---------------------------------------------------------------------------
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH    = PWM_DEFAULT_WIDTH,
    parameter int CHANNELS = PWM_DEFAULT_CHANNELS
) (
    input  logic               clk,
    input  logic               rst_n,
    pwm_multi_channel_if.slave bus
);
    pwm_state_e                r_state, w_state_nxt, w_run_state;
    logic [WIDTH-1:0]          r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0]          r_period, r_pend_period, w_period_app;
    logic [CHANNELS*WIDTH-1:0] r_pend_duty, w_duty_app;
    logic                      r_upd, r_pstart;
    logic                      w_run, w_wrap, w_apply;
    logic [CHANNELS-1:0]       w_pwm;

    // Dropping enable stops the count and the outputs on the very next edge.
    assign w_run   = (r_state != IDLE) && bus.enable;
    // IDLE applies at once; RUN waits for the last cycle of the period.
    // A load on that cycle bypasses the shadow registers.
    assign w_apply = (bus.load || r_upd) && ((r_state == IDLE) || w_wrap);
    assign w_period_app = bus.load ? bus.period : r_pend_period;
    assign w_duty_app   = bus.load ? bus.duty   : r_pend_duty;

`ifdef PWM_CENTER_ALIGNED_EN
    logic r_center, r_pend_center, w_center_app;
    // Mode of the period that starts after this edge.
    assign w_center_app = w_apply ? (bus.load ? bus.center : r_pend_center) : r_center;
    assign w_run_state  = w_center_app ? UP : RUN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_center      <= 1'b0;
            r_pend_center <= 1'b0;
        end else begin
            r_center <= w_center_app;
            if (!w_apply && bus.load) r_pend_center <= bus.center;
        end
    end
`else
    assign w_run_state = RUN;
`endif

    // Last cycle of the period: the counter returns to 0 at the next edge.
    always_comb begin
        w_wrap = 1'b0;
        if (w_run) begin
            case (r_state)
                RUN:     w_wrap = (r_cnt == r_period);
`ifdef PWM_CENTER_ALIGNED_EN
                // P<=1 has no down-count half.
                UP:      w_wrap = (r_cnt == r_period) && (r_period <= WIDTH'(1));
                DOWN:    w_wrap = (r_cnt == WIDTH'(1));
`endif
                default: w_wrap = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        if (r_state == IDLE) begin
            if (bus.enable) w_state_nxt = w_run_state;
        end else if (!bus.enable) begin
            w_state_nxt = IDLE;
        end else if (w_wrap) begin
            w_state_nxt = w_run_state;
        end else begin
            case (r_state)
`ifdef PWM_CENTER_ALIGNED_EN
                UP: begin
                    if (r_cnt == r_period) begin
                        w_state_nxt = DOWN;
                        w_cnt_nxt   = r_cnt - WIDTH'(1);
                    end else begin
                        w_cnt_nxt   = r_cnt + WIDTH'(1);
                    end
                end
                DOWN:    w_cnt_nxt = r_cnt - WIDTH'(1);
`endif
                default: w_cnt_nxt = r_cnt + WIDTH'(1);
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_period      <= '1;
            r_pend_period <= '0;
            r_pend_duty   <= '0;
            r_upd         <= 1'b0;
            r_pstart      <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_pstart <= w_run && (r_cnt == '0);
            if (w_apply) begin
                r_period <= w_period_app;
                r_upd    <= 1'b0;
            end else if (bus.load) begin
                r_pend_period <= bus.period;
                r_pend_duty   <= bus.duty;
                r_upd         <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_compare_channel #(.WIDTH(WIDTH)) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_run   (w_run),
            .i_apply (w_apply),
            .i_cnt   (r_cnt),
            .i_duty  (w_duty_app[i*WIDTH +: WIDTH]),
            .o_pwm   (w_pwm[i])
        );
    end

    assign bus.update_pending = r_upd;
    assign bus.period_start   = r_pstart;
    assign bus.pwm_out        = w_pwm;
endmodule

// File: tb/tb_pwm_multi_channel.sv
// ---------------------------------------------------------------------------
// tb_pwm_multi_channel: directed scenarios plus randomized traffic, checked
// every cycle against a period/position model of the PWM generator.
// ---------------------------------------------------------------------------
module tb_pwm_multi_channel;
    localparam int W = 16;
    localparam int C = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_multi_channel_if #(.WIDTH(W), .CHANNELS(C)) bus ();
    pwm_multi_channel #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_running: counter was running during the cycle just ended
    // m_pos    : position inside the current period (0..m_P)
    bit        m_running, m_pend, m_live, m_last;
    int        m_pos, m_P, m_pP;
    int        m_D[C], m_pD[C];
    bit [C-1:0] exp_pwm;
    bit        exp_ps, exp_upd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_running = 0; m_pend = 0; m_pos = 0; m_P = 65535; m_pP = 0;
            for (int i = 0; i < C; i++) begin m_D[i] = 0; m_pD[i] = 0; end
            exp_pwm = '0; exp_ps = 0; exp_upd = 0;
        end else begin
            m_live = m_running && bus.enable;
            m_last = m_live && (m_pos == m_P);
            for (int i = 0; i < C; i++) exp_pwm[i] = m_live && (m_pos < m_D[i]);
            exp_ps = m_live && (m_pos == 0);
            if ((!m_running || m_last) && (bus.load || m_pend)) begin
                if (bus.load) begin
                    m_P = int'(bus.period);
                    for (int i = 0; i < C; i++) m_D[i] = int'(bus.duty[i*W +: W]);
                end else begin
                    m_P = m_pP;
                    for (int i = 0; i < C; i++) m_D[i] = m_pD[i];
                end
                m_pend = 0;
            end else if (bus.load) begin
                m_pP = int'(bus.period);
                for (int i = 0; i < C; i++) m_pD[i] = int'(bus.duty[i*W +: W]);
                m_pend = 1;
            end
            m_pos     = (m_live && !m_last) ? m_pos + 1 : 0;
            m_running = bus.enable;
            exp_upd   = m_pend;
        end
    end

    bit chk_en = 1'b1;
    always @(negedge clk) begin
        if (chk_en) begin
            check("pwm_out", int'(bus.pwm_out), int'(exp_pwm));
            check("period_start", int'(bus.period_start), int'(exp_ps));
            check("update_pending", int'(bus.update_pending), int'(exp_upd));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_load(input int p, input int d0, input int d1, input int d2, input int d3);
        bus.load   = 1'b1;
        bus.period = W'(p);
        bus.duty   = {W'(d3), W'(d2), W'(d1), W'(d0)};
    endtask

    // Returns at the first negedge showing period_start, n = negedges waited.
    task automatic wait_ps(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.period_start && n < 40);
        check("wait_period_start", int'(bus.period_start), 1);
    endtask

    // Called at a period_start negedge; samples len cycles, then the next start.
    task automatic measure(input int len, input string tag,
                           input int e0, input int e1, input int e2, input int e3);
        int hi[C];
        int ps;
        ps = 0;
        for (int i = 0; i < C; i++) hi[i] = 0;
        for (int k = 0; k < len; k++) begin
            if (k > 0) @(negedge clk);
            for (int i = 0; i < C; i++) hi[i] += int'(bus.pwm_out[i]);
            ps += int'(bus.period_start);
        end
        check({tag, "_ch0_high"}, hi[0], e0);
        check({tag, "_ch1_high"}, hi[1], e1);
        check({tag, "_ch2_high"}, hi[2], e2);
        check({tag, "_ch3_high"}, hi[3], e3);
        check({tag, "_ps_count"}, ps, 1);
        @(negedge clk);
        check({tag, "_next_ps"}, int'(bus.period_start), 1);
    endtask

    initial begin
        int n;
        int acc;
        bus.enable = 1'b0; bus.load = 1'b0; bus.period = '0; bus.duty = '0;

        // 1: reset state, async reset mid-period, idle after release
        repeat (2) @(negedge clk);
        check("rst_pwm", int'(bus.pwm_out), 0);
        check("rst_upd", int'(bus.update_pending), 0);
        check("rst_ps", int'(bus.period_start), 0);
        #1 rst_n = 1'b1;
        @(negedge clk); #1 set_load(9, 3, 0, 10, 5);
        @(negedge clk); #1 bus.load = 1'b0; bus.enable = 1'b1;
        wait_ps(n);
        check("t1_ch0_rise", int'(bus.pwm_out[0]), 1);
        #1 set_load(4, 2, 0, 0, 0);
        @(negedge clk); #1 bus.load = 1'b0;
        check("t1_upd_set", int'(bus.update_pending), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t1_async_pwm", int'(bus.pwm_out), 0);
        check("t1_async_upd", int'(bus.update_pending), 0);
        check("t1_async_ps", int'(bus.period_start), 0);
        @(negedge clk); #1 rst_n = 1'b1;
        acc = 0;
        repeat (20) begin @(negedge clk); acc += int'(bus.pwm_out); end
        check("t1_idle_after_rst", acc, 0);

        // 2: basic duties P=9, D={3,0,10,5}
        #1 bus.enable = 1'b0; set_load(9, 3, 0, 10, 5);
        @(negedge clk); #1 bus.load = 1'b0; bus.enable = 1'b1;
        wait_ps(n);
        measure(10, "t2", 3, 0, 10, 5);

        // 3: load at cnt=4 is held until the wrap
        repeat (3) @(negedge clk);
        #1 set_load(4, 2, 0, 10, 5);
        @(negedge clk); #1 bus.load = 1'b0;
        check("t3_upd_pending", int'(bus.update_pending), 1);
        wait_ps(n);
        check("t3_old_period_tail", n, 6);
        check("t3_upd_cleared", int'(bus.update_pending), 0);
        measure(5, "t3", 2, 0, 5, 5);

        // 4: load on the wrap cycle applies at that wrap
        repeat (3) @(negedge clk);
        #1 set_load(6, 1, 0, 10, 5);
        @(negedge clk); #1 bus.load = 1'b0;
        check("t4_no_pending", int'(bus.update_pending), 0);
        wait_ps(n);
        check("t4_gap", n, 1);
        measure(7, "t4", 1, 0, 7, 5);

        // 5: enable dropped at cnt=6, then a fresh full period
        #1 set_load(9, 3, 0, 10, 5);
        @(negedge clk); #1 bus.load = 1'b0;
        wait_ps(n);
        check("t5_reload_gap", n, 6);
        repeat (5) @(negedge clk);
        #1 bus.enable = 1'b0;
        @(negedge clk);
        check("t5_off_pwm", int'(bus.pwm_out), 0);
        check("t5_off_ps", int'(bus.period_start), 0);
        #1 bus.enable = 1'b1;
        wait_ps(n);
        check("t5_restart_gap", n, 2);
        measure(10, "t5", 3, 0, 10, 5);

        // randomized traffic, including P=0, D>P, enable drops, one async reset
        for (int it = 0; it < 3000; it++) begin
            @(negedge clk); #1;
            bus.load = ($urandom_range(0, 5) == 0);
            if (bus.load) begin
                bus.period = W'($urandom_range(0, 12));
                for (int i = 0; i < C; i++) bus.duty[i*W +: W] = W'($urandom_range(0, 14));
            end
            if (bus.enable) bus.enable = ($urandom_range(0, 39) != 0);
            else            bus.enable = ($urandom_range(0, 3) == 0);
            if (it == 1500) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
